// File: rtl/bincnt_pkg.sv
// Shared types and helpers for the serial population-count controller.
package bincnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 4-bit chunks in a word.
  function automatic int nchunk_of(input int width);
    return width / 4;
  endfunction

  // Count width: enough bits to hold the value WIDTH itself.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

  // Chunk index width, never below one bit (WIDTH=4 has a single chunk).
  function automatic int idxw_of(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  // Thermometer (filled from the MSB) to binary count, 0..4.
  function automatic logic [2:0] t2b(input logic [3:0] y);
    logic [2:0] cnt;
    cnt[2] = y[0];
    cnt[1] = y[2] & ~y[0];
    cnt[0] = ^y;
    return cnt;
  endfunction

endpackage

// File: rtl/sorter4b.sv
// 4-input bit sorter: pushes all ones toward the MSB (y[3]=OR, y[0]=AND).
module sorter4b (
  input  logic [3:0] x,
  output logic [3:0] y
);

  logic hi01, lo01, hi23, lo23, mid_hi, mid_lo;

  // Compare-exchange network: sort pairs, merge extremes, then fix the middle.
  always_comb begin
    hi01   = x[0] | x[1];
    lo01   = x[0] & x[1];
    hi23   = x[2] | x[3];
    lo23   = x[2] & x[3];
    mid_hi = hi01 & hi23;
    mid_lo = lo01 | lo23;
    y[3]   = hi01 | hi23;
    y[2]   = mid_hi | mid_lo;
    y[1]   = mid_hi & mid_lo;
    y[0]   = lo01 & lo23;
  end

endmodule

// File: rtl/bincnt_seq.sv
// Serial popcount: one shared sorter4b counts a WIDTH-bit word 4 bits per cycle.
module bincnt_seq
  import bincnt_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int NCHUNK = nchunk_of(WIDTH);
  localparam int IW     = idxw_of(NCHUNK);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("bincnt_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    out_count_q, out_count_d;

  logic [3:0]       sort_y;
  logic [CW-1:0]    sum;

  sorter4b u_sorter (
    .x (shreg_q[3:0]),
    .y (sort_y)
  );

  // Running total including the chunk currently at the bottom of the shift register.
  assign sum = acc_q + CW'(t2b(sort_y));

  // Next-state logic: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_d = in_data;
            acc_d   = '0;
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          acc_d   = sum;
          shreg_d = shreg_q >> 4;
          idx_d   = idx_q + IW'(1);
          if (idx_q == IW'(NCHUNK - 1)) begin
            out_count_d = sum;
            idx_d       = '0;
            state_d     = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_count = out_count_q;

endmodule

// File: tb/tb_bincnt_seq.sv
// Self-checking bench for bincnt_seq (WIDTH=16) against a popcount reference.
module tb_bincnt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_count;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  bincnt_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: number of set bits in the word.
  function automatic int ref_count(input logic [15:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(w[i]);
    return s;
  endfunction

  // Offers one word, waits for the result, then completes the output handshake.
  // Called and returns at a falling edge.
  task automatic run_word(input logic [15:0] w, input int ready_delay,
                          output logic [4:0] cnt, output logic [4:0] cnt_late,
                          output int lat, output bit to);
    int n;
    to = 1'b0; lat = 0; cnt = '0; cnt_late = '0; n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin to = 1'b1; return; end
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) begin to = 1'b1; return; end
    cnt = out_count;
    repeat (ready_delay) @(negedge clk);
    cnt_late = out_count;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_count !== 5'd0) $display("FAIL reset_out_count: got %0d expected 0", out_count); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] words [4];
    int          exps  [4];
    logic [4:0]  cnt, cnt_late;
    int          lat;
    bit          to;
    words = '{16'hFFFF, 16'h0000, 16'hA5C3, 16'h8001};
    exps  = '{16, 0, 8, 2};
    for (int i = 0; i < 4; i++) begin
      run_word(words[i], 0, cnt, cnt_late, lat, to);
      $display("basic word=%h count=%0d latency=%0d", words[i], cnt, lat);
      n_checks++; if (to) $display("FAIL basic_timeout: word %h got no result, expected one", words[i]); else n_pass++;
      n_checks++; if (cnt !== 5'(exps[i])) $display("FAIL basic_count: word %h got %0d expected %0d", words[i], cnt, exps[i]); else n_pass++;
      n_checks++; if (lat != 4) $display("FAIL basic_latency: word %h got %0d expected 4", words[i], lat); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_idle_after: got in_ready %b expected 1", in_ready); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit bad_cnt, bad_rdy, bad_vld;
    n = 0; bad_cnt = 0; bad_rdy = 0; bad_vld = 0;
    in_valid = 1'b1; in_data = 16'h00F0;
    @(negedge clk);
    in_data = 16'h0F0F;                       // competing word, held valid throughout
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++; if (n != 4) $display("FAIL bp_latency: got %0d expected 4", n); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      if (out_count !== 5'd4) bad_cnt = 1;
      if (in_ready !== 1'b0) bad_rdy = 1;
      if (out_valid !== 1'b1 || busy !== 1'b1) bad_vld = 1;
      @(negedge clk);
    end
    $display("backpressure word=00f0 count=%0d held 10 cycles", out_count);
    n_checks++; if (bad_cnt) $display("FAIL bp_count_stable: got %0d expected 4", out_count); else n_pass++;
    n_checks++; if (bad_rdy) $display("FAIL bp_in_ready: got %b expected 0 while DONE", in_ready); else n_pass++;
    n_checks++; if (bad_vld) $display("FAIL bp_out_valid: got %b expected 1 while held", out_valid); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_idle: got %b expected 1", in_ready); else n_pass++;
    @(negedge clk);                           // competing word accepted on this edge
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    $display("backpressure word=0f0f count=%0d latency=%0d", out_count, n);
    n_checks++; if (out_count !== 5'd8) $display("FAIL bp_second_count: got %0d expected 8", out_count); else n_pass++;
    n_checks++; if (n != 4) $display("FAIL bp_second_latency: got %0d expected 4", n); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit         seen;
    logic [4:0] cnt, cnt_late;
    int         lat;
    bit         to;
    seen = 0;
    // Abort in IDLE must win over in_valid.
    abort = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle_no_accept: got busy %b expected 0", busy); else n_pass++;
    // Abort on the second RUN cycle.
    in_valid = 1'b1; in_data = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL abort_to_idle: got in_ready %b expected 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    n_checks++; if (seen) $display("FAIL abort_no_result: got out_valid 1 expected 0"); else n_pass++;
    run_word(16'h0001, 0, cnt, cnt_late, lat, to);
    $display("after-abort word=0001 count=%0d latency=%0d", cnt, lat);
    n_checks++; if (to || cnt !== 5'd1) $display("FAIL abort_next_count: got %0d expected 1 (timeout=%0b)", cnt, to); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int         n_acc, cyc0, cyc1, nres;
    logic [4:0] c0, c1;
    n_acc = 0; nres = 0; cyc0 = 0; cyc1 = 0; c0 = '0; c1 = '0;
    // Reset in the middle of RUN.
    in_valid = 1'b1; in_data = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b expected 1", busy); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_count !== 5'd0) $display("FAIL rst_async_count: got %0d expected 0", out_count); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // Back-to-back words with the consumer always ready.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (n_acc == 1) in_data = 16'h7777;
      if (n_acc == 2) in_valid = 1'b0;
      if (out_valid) begin
        if (nres == 0) begin cyc0 = cyc; c0 = out_count; end
        else if (nres == 1) begin cyc1 = cyc; c1 = out_count; end
        nres++;
      end
      if (in_ready && in_valid) n_acc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    $display("back-to-back counts=%0d,%0d at cycles %0d,%0d", c0, c1, cyc0, cyc1);
    n_checks++; if (nres != 2) $display("FAIL b2b_results: got %0d expected 2", nres); else n_pass++;
    n_checks++; if (c0 !== 5'd4) $display("FAIL b2b_first_count: got %0d expected 4", c0); else n_pass++;
    n_checks++; if (c1 !== 5'd12) $display("FAIL b2b_second_count: got %0d expected 12", c1); else n_pass++;
    n_checks++; if (cyc1 - cyc0 != 6) $display("FAIL b2b_spacing: got %0d expected 6", cyc1 - cyc0); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [4:0]  cnt, cnt_late;
    int          lat, exp_c, dly;
    bit          to;
    for (int i = 0; i < 24; i++) begin
      w     = 16'($urandom);
      dly   = int'($urandom_range(0, 3));
      exp_c = ref_count(w);
      run_word(w, dly, cnt, cnt_late, lat, to);
      $display("random word=%h count=%0d expected=%0d latency=%0d ready_delay=%0d", w, cnt, exp_c, lat, dly);
      n_checks++; if (to || cnt !== 5'(exp_c)) $display("FAIL rand_count: word %h got %0d expected %0d", w, cnt, exp_c); else n_pass++;
      n_checks++; if (cnt_late !== 5'(exp_c)) $display("FAIL rand_hold: word %h got %0d expected %0d", w, cnt_late, exp_c); else n_pass++;
      n_checks++; if (lat != 4) $display("FAIL rand_latency: word %h got %0d expected 4", w, lat); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
